// File: rtl/matmul_load_sequencer_if.sv
// matmul_load_sequencer_if
// Bundles the UART byte stream, the arm/release control pulses and the
// operand-memory write port of the load sequencer.
//   master : the sequencer (consumes rx/arm/release_req, drives writes/flags)
//   slave  : the surrounding system (UART, multiplier FSM, memories)
// The consumer "release" pulse is carried as release_req because release is
// a reserved word in SystemVerilog.
interface matmul_load_sequencer_if;
  logic       arm;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       release_req;
  logic       wr_en_a;
  logic       wr_en_b;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       loaded_a;
  logic       loaded_b;
  logic       busy;
  logic       err;

  modport master (
    input  arm, rx_valid, rx_byte, release_req,
    output wr_en_a, wr_en_b, wr_addr, wr_data, loaded_a, loaded_b, busy, err
  );

  modport slave (
    output arm, rx_valid, rx_byte, release_req,
    input  wr_en_a, wr_en_b, wr_addr, wr_data, loaded_a, loaded_b, busy, err
  );
endinterface

// File: rtl/matmul_load_sequencer.sv
// matmul_load_sequencer
// Loads the A then B operand memories (N = ROW*COLUMN bytes each, row-major)
// from one UART byte stream, raising loaded_a / loaded_b for the multiplier.
// A stalled sender is detected by an inter-byte gap counter (TIMEOUT cycles).
// Optional build macro CHECKSUM_EN: a trailing byte must equal the mod-256 sum
// of all 2N element bytes before the load is reported complete.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       matmul_load_sequencer_if.master
//             in : arm, rx_valid, rx_byte[7:0], release_req
//             out: wr_en_a, wr_en_b, wr_addr[7:0], wr_data[7:0],
//                  loaded_a, loaded_b, busy, err
module matmul_load_sequencer #(
  parameter int ROW     = 3,
  parameter int COLUMN  = 3,
  parameter int TIMEOUT = 100000
) (
  input  logic                           clk,
  input  logic                           rst,
  matmul_load_sequencer_if.master        bus
);
  localparam int N     = ROW * COLUMN;
  localparam int GAP_W = $clog2(TIMEOUT);
  localparam logic [7:0]       LAST_IDX = 8'(N - 1);
  // Expiry fires on the idle cycle that would take the gap count to TIMEOUT.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, DONE
`ifdef CHECKSUM_EN
    , CHK
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             we_a_q, we_a_d, we_b_q, we_b_d;
  logic [7:0]       addr_q, addr_d, data_q, data_d;
  logic             la_q, la_d, lb_q, lb_d, err_q, err_d;
  logic             abort;
`ifdef CHECKSUM_EN
  logic [7:0]       sum_q, sum_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      we_a_q  <= 1'b0;
      we_b_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      la_q    <= 1'b0;
      lb_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      we_a_q  <= we_a_d;
      we_b_q  <= we_b_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
      err_q   <= err_d;
`ifdef CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    we_a_d  = 1'b0;
    we_b_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    la_d    = la_q;
    lb_d    = lb_q;
    err_d   = err_q;
    abort   = 1'b0;
`ifdef CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.arm) begin
          state_d = LOAD_A;
          idx_d   = '0;
          gap_d   = '0;
          err_d   = 1'b0;
`ifdef CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      LOAD_A, LOAD_B: begin
        // A byte arriving on the expiry cycle is still taken.
        if (bus.rx_valid) begin
          gap_d  = '0;
          addr_d = idx_q;
          data_d = bus.rx_byte;
          we_a_d = (state_q == LOAD_A);
          we_b_d = (state_q == LOAD_B);
`ifdef CHECKSUM_EN
          sum_d  = sum_q + bus.rx_byte;
`endif
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (state_q == LOAD_A) begin
              la_d    = 1'b1;
              state_d = LOAD_B;
            end else begin
              lb_d    = 1'b1;
`ifdef CHECKSUM_EN
              state_d = CHK;
`else
              state_d = DONE;
`endif
            end
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else if (gap_q == GAP_LAST) begin
          abort = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
`ifdef CHECKSUM_EN
      CHK: begin
        // Trailer byte is compared only, never written to memory.
        if (bus.rx_valid) begin
          gap_d = '0;
          if (bus.rx_byte == sum_q) state_d = DONE;
          else                      abort   = 1'b1;
        end else if (gap_q == GAP_LAST) begin
          abort = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
`endif
      DONE: begin
        if (bus.release_req) begin
          state_d = IDLE;
          la_d    = 1'b0;
          lb_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      err_d   = 1'b1;
      state_d = IDLE;
      la_d    = 1'b0;
      lb_d    = 1'b0;
      idx_d   = '0;
      gap_d   = '0;
    end
  end

  assign bus.wr_en_a  = we_a_q;
  assign bus.wr_en_b  = we_b_q;
  assign bus.wr_addr  = addr_q;
  assign bus.wr_data  = data_q;
  assign bus.loaded_a = la_q;
  assign bus.loaded_b = lb_q;
  assign bus.err      = err_q;
`ifdef CHECKSUM_EN
  assign bus.busy = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == CHK);
`else
  assign bus.busy = (state_q == LOAD_A) || (state_q == LOAD_B);
`endif
endmodule

// File: tb/tb_matmul_load_sequencer.sv
// tb_matmul_load_sequencer
// Drives matmul_load_sequencer (TIMEOUT = 16) through directed and random
// byte streams and compares every output each cycle with a byte-count based
// reference model of the load protocol.
module tb_matmul_load_sequencer;
  localparam int N   = 9;
  localparam int TMO = 16;

  logic clk, rst;
  matmul_load_sequencer_if bus();

  matmul_load_sequencer #(.ROW(3), .COLUMN(3), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cnt_a = 0;
  int cnt_b = 0;

  // Reference model: phase 0 idle, 1 loading (A, B or trailer), 2 done.
  int         m_phase, m_cnt, m_idle;
  logic       m_we_a, m_we_b, m_la, m_lb, m_err;
  logic [7:0] m_addr, m_data, m_sum;

  logic [21:0] obs;
  assign obs = {bus.wr_en_a, bus.wr_en_b, bus.wr_addr, bus.wr_data,
                bus.loaded_a, bus.loaded_b, bus.busy, bus.err};

  function automatic logic [21:0] mexp();
    return {m_we_a, m_we_b, m_addr, m_data, m_la, m_lb, (m_phase == 1), m_err};
  endfunction

  task automatic m_reset();
    m_phase = 0; m_cnt = 0; m_idle = 0;
    m_we_a = 0; m_we_b = 0; m_la = 0; m_lb = 0; m_err = 0;
    m_addr = 0; m_data = 0; m_sum = 0;
  endtask

  task automatic m_abort();
    m_err = 1; m_la = 0; m_lb = 0; m_phase = 0;
  endtask

  task automatic model_edge(input bit a, input bit v, input logic [7:0] b, input bit r);
    m_we_a = 0; m_we_b = 0;
    if (m_phase == 0) begin
      if (a) begin m_phase = 1; m_cnt = 0; m_idle = 0; m_err = 0; m_sum = 0; end
    end else if (m_phase == 2) begin
      if (r) begin m_phase = 0; m_la = 0; m_lb = 0; end
    end else if (v) begin
      m_idle = 0;
      if (m_cnt < 2*N) begin
        if (m_cnt < N) m_we_a = 1; else m_we_b = 1;
        m_addr = 8'(m_cnt % N);
        m_data = b;
        m_sum  = m_sum + b;
        m_cnt++;
        if (m_cnt == N) m_la = 1;
        if (m_cnt == 2*N) begin
          m_lb = 1;
`ifndef CHECKSUM_EN
          m_phase = 2;
`endif
        end
      end else begin
        if (b == m_sum) m_phase = 2; else m_abort();
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) m_abort();
    end
  endtask

  task automatic cyc(input bit a, input bit v, input logic [7:0] b, input bit r);
    bus.arm = a; bus.rx_valid = v; bus.rx_byte = b; bus.release_req = r;
    @(posedge clk);
    model_edge(a, v, b, r);
    #1;
    if (bus.wr_en_a) cnt_a++;
    if (bus.wr_en_b) cnt_b++;
    bus.arm = 0; bus.rx_valid = 0; bus.release_req = 0;
  endtask

  // base < 0 selects random data, otherwise data = base + k.
  task automatic send_bytes(input int n, input int gap, input int base, input string tag);
    for (int k = 0; k < n; k++) begin
      cyc(0, 1, (base < 0) ? 8'($urandom) : 8'(base + k), 0);
      vecs++;
      if (obs !== mexp()) begin
        errs++;
        $display("FAIL %s byte %0d: got %h want %h", tag, k, obs, mexp());
      end
      for (int g = 0; g < gap; g++) begin
        cyc(0, 0, 8'h00, 0);
        vecs++;
        if (obs !== mexp()) begin
          errs++;
          $display("FAIL %s gap %0d/%0d: got %h want %h", tag, k, g, obs, mexp());
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.arm = 0; bus.rx_valid = 0; bus.rx_byte = 0; bus.release_req = 0;
    m_reset();
    #12;
    vecs++;
    if (obs !== 22'h0) begin errs++; $display("FAIL reset_state: got %h want 0", obs); end
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 1, 8'h5A, 0);
    vecs++;
    if (obs !== 22'h0) begin errs++; $display("FAIL idle_rx_ignored: got %h want 0", obs); end
  endtask

  task automatic test_nominal();
    cnt_a = 0; cnt_b = 0;
    cyc(1, 0, 8'h00, 0);
    vecs++;
    if (bus.busy !== 1'b1) begin errs++; $display("FAIL nominal_arm_busy: got %b want 1", bus.busy); end
    send_bytes(8, 3, 1, "nominal_a");
    cyc(0, 1, 8'd9, 0);
    vecs++;
    if ({bus.wr_en_a, bus.wr_addr, bus.wr_data, bus.loaded_a} !== {1'b1, 8'd8, 8'd9, 1'b1}) begin
      errs++; $display("FAIL nominal_9th: got %h want %h", {bus.wr_en_a, bus.wr_addr, bus.wr_data, bus.loaded_a}, {1'b1, 8'd8, 8'd9, 1'b1});
    end
    send_bytes(8, 3, 10, "nominal_b");
    cyc(0, 1, 8'd18, 0);
    vecs++;
    if ({bus.wr_en_b, bus.wr_addr, bus.wr_data, bus.loaded_b} !== {1'b1, 8'd8, 8'd18, 1'b1}) begin
      errs++; $display("FAIL nominal_18th: got %h want %h", {bus.wr_en_b, bus.wr_addr, bus.wr_data, bus.loaded_b}, {1'b1, 8'd8, 8'd18, 1'b1});
    end
`ifdef CHECKSUM_EN
    cyc(0, 1, 8'd171, 0);
`endif
    vecs++;
    if ({cnt_a, cnt_b, bus.busy, bus.loaded_a} !== {32'd9, 32'd9, 1'b0, 1'b1}) begin
      errs++; $display("FAIL nominal_counts: got a=%0d b=%0d busy=%b la=%b want 9 9 0 1", cnt_a, cnt_b, bus.busy, bus.loaded_a);
    end
    cyc(0, 0, 8'h00, 1);
    vecs++;
    if ({bus.loaded_a, bus.loaded_b} !== 2'b00) begin
      errs++; $display("FAIL release_flags: got %b want 00", {bus.loaded_a, bus.loaded_b});
    end
  endtask

  task automatic test_back_to_back();
    cnt_a = 0; cnt_b = 0;
    cyc(1, 0, 8'h00, 0);
    send_bytes(2*N, 0, -1, "b2b");
`ifdef CHECKSUM_EN
    cyc(0, 1, m_sum, 0);
`endif
    vecs++;
    if ({cnt_a, cnt_b, bus.loaded_a, bus.loaded_b, bus.busy} !== {32'd9, 32'd9, 3'b110}) begin
      errs++; $display("FAIL b2b_done: got a=%0d b=%0d flags=%b want 9 9 110", cnt_a, cnt_b, {bus.loaded_a, bus.loaded_b, bus.busy});
    end
    cyc(0, 0, 8'h00, 1);
  endtask

  task automatic test_timeout();
    cyc(1, 0, 8'h00, 0);
    send_bytes(5, 0, 40, "tmo");
    send_bytes(0, 0, 0, "tmo");
    for (int g = 0; g < TMO - 1; g++) cyc(0, 0, 8'h00, 0);
    vecs++;
    if ({bus.err, bus.busy} !== 2'b01) begin errs++; $display("FAIL tmo_early: got %b want 01", {bus.err, bus.busy}); end
    cyc(0, 0, 8'h00, 0);
    vecs++;
    if ({bus.err, bus.busy, bus.loaded_a, bus.wr_en_a} !== 4'b1000) begin
      errs++; $display("FAIL tmo_expire: got %b want 1000", {bus.err, bus.busy, bus.loaded_a, bus.wr_en_a});
    end
    cyc(1, 0, 8'h00, 0);
    vecs++;
    if ({bus.err, bus.busy} !== 2'b01) begin errs++; $display("FAIL tmo_rearm: got %b want 01", {bus.err, bus.busy}); end
    send_bytes(1, 0, 77, "tmo_restart");
    vecs++;
    if ({bus.wr_en_a, bus.wr_addr} !== {1'b1, 8'd0}) begin
      errs++; $display("FAIL tmo_restart_addr: got %h want %h", {bus.wr_en_a, bus.wr_addr}, {1'b1, 8'd0});
    end
    send_bytes(1, TMO, 0, "tmo_cleanup");
  endtask

  task automatic test_expiry_edge();
    cyc(1, 0, 8'h00, 0);
    send_bytes(1, TMO - 1, 3, "edge");
    cyc(0, 1, 8'hE7, 0);
    vecs++;
    if ({bus.wr_en_a, bus.wr_addr, bus.wr_data, bus.err, bus.busy} !== {1'b1, 8'd1, 8'hE7, 2'b01}) begin
      errs++; $display("FAIL edge_accept: got %h want %h", {bus.wr_en_a, bus.wr_addr, bus.wr_data, bus.err, bus.busy}, {1'b1, 8'd1, 8'hE7, 2'b01});
    end
    send_bytes(0, 0, 0, "edge");
    for (int g = 0; g < TMO; g++) cyc(0, 0, 8'h00, 0);
    vecs++;
    if (obs !== mexp()) begin errs++; $display("FAIL edge_cleanup: got %h want %h", obs, mexp()); end
  endtask

  task automatic test_ignored();
    cyc(1, 0, 8'h00, 0);
    send_bytes(2, 1, 50, "ign");
    cyc(0, 0, 8'h00, 1);
    vecs++;
    if ({bus.busy, bus.loaded_a} !== 2'b10) begin errs++; $display("FAIL ign_release_in_a: got %b want 10", {bus.busy, bus.loaded_a}); end
    send_bytes(9, 0, 60, "ign");
    cyc(1, 0, 8'h00, 0);
    send_bytes(1, 0, 99, "ign");
    vecs++;
    if ({bus.wr_en_b, bus.wr_addr, bus.wr_data} !== {1'b1, 8'd2, 8'd99}) begin
      errs++; $display("FAIL ign_arm_in_b: got %h want %h", {bus.wr_en_b, bus.wr_addr, bus.wr_data}, {1'b1, 8'd2, 8'd99});
    end
    send_bytes(6, 0, -1, "ign");
`ifdef CHECKSUM_EN
    cyc(0, 1, m_sum, 0);
`endif
    cyc(1, 0, 8'h00, 0);
    vecs++;
    if ({bus.loaded_a, bus.loaded_b, bus.busy} !== 3'b110) begin
      errs++; $display("FAIL ign_arm_in_done: got %b want 110", {bus.loaded_a, bus.loaded_b, bus.busy});
    end
    cyc(1, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 0);
    vecs++;
    if ({bus.loaded_a, bus.loaded_b, bus.busy} !== 3'b000) begin
      errs++; $display("FAIL arm_release_same_cycle: got %b want 000", {bus.loaded_a, bus.loaded_b, bus.busy});
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 0, 8'h00, 0);
    send_bytes(12, 0, 20, "rstmid");
    #2 rst = 1'b1;
    #1;
    vecs++;
    if (obs !== 22'h0) begin errs++; $display("FAIL reset_mid_load: got %h want 0", obs); end
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum();
    cyc(1, 0, 8'h00, 0);
    send_bytes(2*N, 0, 1, "chk_ok");
    cyc(0, 1, 8'hAB, 0);
    vecs++;
    if ({bus.loaded_a, bus.loaded_b, bus.busy, bus.err, bus.wr_en_b} !== 5'b11000) begin
      errs++; $display("FAIL chk_match: got %b want 11000", {bus.loaded_a, bus.loaded_b, bus.busy, bus.err, bus.wr_en_b});
    end
    cyc(0, 0, 8'h00, 1);
    cyc(1, 0, 8'h00, 0);
    send_bytes(2*N, 0, 1, "chk_bad");
    cyc(0, 1, 8'hAC, 0);
    vecs++;
    if ({bus.loaded_a, bus.loaded_b, bus.busy, bus.err} !== 4'b0001) begin
      errs++; $display("FAIL chk_mismatch: got %b want 0001", {bus.loaded_a, bus.loaded_b, bus.busy, bus.err});
    end
  endtask
`endif

  task automatic test_random();
    int stall = 0;
    bit a, v, r;
    logic [7:0] b;
    for (int c = 0; c < 1500; c++) begin
      a = ($urandom_range(0, 29) == 0) || (m_phase == 0 && $urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 9) == 0);
      if (stall > 0) begin v = 0; stall--; end
      else begin
        v = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 59) == 0) stall = $urandom_range(TMO - 2, TMO + 2);
      end
      b = 8'($urandom);
      if (m_phase == 1 && m_cnt == 2*N && $urandom_range(0, 1) == 0) b = m_sum;
      cyc(a, v, b, r);
      vecs++;
      if (obs !== mexp()) begin
        errs++;
        $display("FAIL random cycle %0d: got %h want %h", c, obs, mexp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_timeout();
    test_expiry_edge();
    test_ignored();
    test_reset_mid();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
